// File: rtl/pwm_ctrl_pkg.sv
// Shared state type and constants for the PWM sequencer blocks.
package pwm_ctrl_pkg;

  localparam int unsigned HOLD_BITS = 8;
  localparam int unsigned R_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    DWELL = 2'd2
  } state_e;

  // Full-scale duty for an r-bit PWM (2^r == 100 %).
  function automatic int unsigned duty_max(input int unsigned r);
    return 32'd1 << r;
  endfunction

  localparam int unsigned DUTY_MAX = duty_max(R_DEFAULT);

endpackage

// File: rtl/pwm_period_tracker.sv
// Mirrors the PWM prescaler and period counter; flags the last cycle of each period
// (boundary_c) and pulses period_start on the first cycle of the next one.
module pwm_period_tracker #(
  parameter int unsigned R          = 8,
  parameter int unsigned TIMER_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [TIMER_BITS-1:0] final_value,
  output logic                  boundary_c,
  output logic                  period_start
);

  logic [TIMER_BITS-1:0] presc_q;
  logic [R-1:0]          period_q;
  logic                  tick_c;

  assign tick_c     = (presc_q == final_value);
  assign boundary_c = tick_c && (period_q == {R{1'b1}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q      <= '0;
      period_q     <= '0;
      period_start <= 1'b0;
    end else begin
      presc_q      <= tick_c ? '0 : presc_q + TIMER_BITS'(1);
      if (tick_c) begin
        period_q <= period_q + R'(1);
      end
      period_start <= boundary_c;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Command-driven duty ramp sequencer for PWM; duty and FINAL_VALUE change only on period
// boundaries. Define PWM_RAMP_ABORT_EN to add the abort input.
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned R                = 8,
  parameter int unsigned TIMER_BITS       = 8,
  parameter int unsigned INIT_FINAL_VALUE = 194
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [R:0]            cmd_target,
  input  logic [R-1:0]          cmd_step,
  input  logic [HOLD_BITS-1:0]  cmd_hold,
  input  logic [TIMER_BITS-1:0] cmd_final_value,
`ifdef PWM_RAMP_ABORT_EN
  input  logic                  abort,
`endif
  output logic [R:0]            duty,
  output logic [TIMER_BITS-1:0] FINAL_VALUE,
  output logic                  period_start,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned DW = R + 1;
  localparam logic [R:0] DUTY_MAX_R = DW'(duty_max(R));
  localparam logic [TIMER_BITS-1:0] FV_RESET = TIMER_BITS'(INIT_FINAL_VALUE);

  state_e                state_q, state_d;
  logic [R:0]            tgt_q, tgt_d;
  logic [R-1:0]          step_q, step_d;
  logic [HOLD_BITS-1:0]  hold_q, hold_d;
  logic [HOLD_BITS-1:0]  hold_cnt_q, hold_cnt_d;
  logic [TIMER_BITS-1:0] fv_sh_q, fv_sh_d;
  logic [TIMER_BITS-1:0] fv_d;
  logic [R:0]            duty_d;
  logic                  done_d, ready_d, busy_d;

  logic                  boundary_c;
  logic                  abort_c;
  logic                  apply_step_c;
  logic [R:0]            tgt_norm_c;
  logic [R-1:0]          step_norm_c;
  logic [R:0]            step_ext_c, diff_c, mag_c, stepped_c;

`ifdef PWM_RAMP_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  pwm_period_tracker #(
    .R          (R),
    .TIMER_BITS (TIMER_BITS)
  ) u_tracker (
    .clk          (clk),
    .reset_n      (reset_n),
    .final_value  (FINAL_VALUE),
    .boundary_c   (boundary_c),
    .period_start (period_start)
  );

  // Command normalisation: clamp target to full scale, zero step means one.
  assign tgt_norm_c  = (cmd_target > DUTY_MAX_R) ? DUTY_MAX_R : cmd_target;
  assign step_norm_c = (cmd_step == '0) ? R'(1) : cmd_step;

  // One step toward the target, never past it.
  assign step_ext_c = {1'b0, step_q};
  assign diff_c     = (duty >= tgt_q) ? (duty - tgt_q) : (tgt_q - duty);
  assign mag_c      = (step_ext_c < diff_c) ? step_ext_c : diff_c;
  assign stepped_c  = (duty < tgt_q) ? (duty + mag_c) : (duty - mag_c);

  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    step_d       = step_q;
    hold_d       = hold_q;
    hold_cnt_d   = hold_cnt_q;
    fv_sh_d      = fv_sh_q;
    fv_d         = FINAL_VALUE;
    duty_d       = duty;
    done_d       = 1'b0;
    apply_step_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          tgt_d   = tgt_norm_c;
          step_d  = step_norm_c;
          hold_d  = cmd_hold;
          fv_sh_d = cmd_final_value;
          state_d = ARM;
        end
      end
      ARM: begin
        if (abort_c) begin
          state_d = IDLE;
        end else if (boundary_c) begin
          fv_d         = fv_sh_q;
          apply_step_c = 1'b1;
        end
      end
      DWELL: begin
        if (abort_c) begin
          state_d = IDLE;
        end else if (boundary_c) begin
          if (hold_cnt_q == '0) begin
            apply_step_c = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q - HOLD_BITS'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (apply_step_c) begin
      duty_d = stepped_c;
      if (stepped_c == tgt_q) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        hold_cnt_d = hold_q;
        state_d    = DWELL;
      end
    end

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tgt_q       <= '0;
      step_q      <= '0;
      hold_q      <= '0;
      hold_cnt_q  <= '0;
      fv_sh_q     <= '0;
      FINAL_VALUE <= FV_RESET;
      duty        <= '0;
      done        <= 1'b0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      step_q      <= step_d;
      hold_q      <= hold_d;
      hold_cnt_q  <= hold_cnt_d;
      fv_sh_q     <= fv_sh_d;
      FINAL_VALUE <= fv_d;
      duty        <= duty_d;
      done        <= done_d;
      cmd_ready   <= ready_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: a period/ramp reference model checked every cycle, plus
// hand-computed expectations for the documented ramp scenarios.
module tb_pwm_ramp_ctrl;

  logic       clk             = 1'b0;
  logic       reset_n         = 1'b0;
  logic       cmd_valid       = 1'b0;
  logic       cmd_ready;
  logic [8:0] cmd_target      = '0;
  logic [7:0] cmd_step        = '0;
  logic [7:0] cmd_hold        = '0;
  logic [7:0] cmd_final_value = '0;
  logic       abort           = 1'b0;
  logic [8:0] duty;
  logic [7:0] FINAL_VALUE;
  logic       period_start;
  logic       busy;
  logic       done;

  int errors   = 0;
  int checks   = 0;
  bit chk_en   = 1'b0;
  bit reported = 1'b0;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(
    .R                (8),
    .TIMER_BITS       (8),
    .INIT_FINAL_VALUE (194)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_target      (cmd_target),
    .cmd_step        (cmd_step),
    .cmd_hold        (cmd_hold),
    .cmd_final_value (cmd_final_value),
`ifdef PWM_RAMP_ABORT_EN
    .abort           (abort),
`endif
    .duty            (duty),
    .FINAL_VALUE     (FINAL_VALUE),
    .period_start    (period_start),
    .busy            (busy),
    .done            (done)
  );

  task automatic finish_run();
    if (!reported) begin
      reported = 1'b1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      if (errors >= 40) finish_run();
    end
  endtask

  // Reference model: time since period start, ramp as "boundaries until next step".
  int m_cnt    = 0;
  int m_fv     = 194;
  int m_duty   = 0;
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  bit m_ps     = 1'b0;
  int m_left   = 0;
  int m_tgt    = 0;
  int m_step   = 1;
  int m_hold   = 0;
  int m_sfv    = 0;

  initial begin : model_proc
    bit bnd;
    int gap;
    int mag;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_cnt    = 0;
        m_fv     = 194;
        m_duty   = 0;
        m_active = 1'b0;
        m_done   = 1'b0;
        m_ps     = 1'b0;
      end else begin
        bnd    = (m_cnt == (m_fv + 1) * 256 - 1);
        m_ps   = bnd;
        m_done = 1'b0;
        m_cnt  = bnd ? 0 : m_cnt + 1;
        if (!m_active) begin
          if (cmd_valid) begin
            m_tgt    = (int'(cmd_target) > 256) ? 256 : int'(cmd_target);
            m_step   = (cmd_step == 8'd0) ? 1 : int'(cmd_step);
            m_hold   = int'(cmd_hold);
            m_sfv    = int'(cmd_final_value);
            m_active = 1'b1;
            m_left   = 1;
          end
        end else if (abort) begin
          m_active = 1'b0;
        end else if (bnd) begin
          m_left--;
          if (m_left == 0) begin
            m_fv = m_sfv;
            gap  = (m_tgt > m_duty) ? m_tgt - m_duty : m_duty - m_tgt;
            mag  = (m_step < gap) ? m_step : gap;
            m_duty = (m_tgt > m_duty) ? m_duty + mag : m_duty - mag;
            if (m_duty == m_tgt) begin
              m_done   = 1'b1;
              m_active = 1'b0;
            end else begin
              m_left = m_hold + 1;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("duty", int'(duty), m_duty);
      check("final_value", int'(FINAL_VALUE), m_fv);
      check("cmd_ready", int'(cmd_ready), int'(!m_active));
      check("busy", int'(busy), int'(m_active));
      check("done", int'(done), int'(m_done));
      check("period_start", int'(period_start), int'(m_ps));
    end
  end

  task automatic send(input int t, input int s, input int h, input int f);
    int n = 0;
    while (!cmd_ready && n < 30000) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready", int'(cmd_ready), 1);
    cmd_target      = 9'(t);
    cmd_step        = 8'(s);
    cmd_hold        = 8'(h);
    cmd_final_value = 8'(f);
    cmd_valid       = 1'b1;
    @(posedge clk); #1;
    cmd_valid       = 1'b0;
    cmd_target      = 9'($urandom_range(0, 511));
    cmd_step        = 8'($urandom_range(0, 255));
    cmd_hold        = 8'($urandom_range(0, 255));
    cmd_final_value = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_ps(input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!period_start && n < limit);
    check("period_start_seen", int'(period_start), 1);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_reached", int'(busy), 0);
  endtask

  initial begin : main_proc
    int n;
    int exp2 [3];
    int exp3 [5];
    int tgt;
    exp2 = '{64, 96, 128};
    exp3 = '{78, 78, 28, 28, 10};

    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk) reset_n = 1'b1;
    #1;
    check("rst_duty", int'(duty), 0);
    check("rst_fv", int'(FINAL_VALUE), 194);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);

    // Ramp 0 -> 128 by 32, first boundary at the reset prescaler value.
    send(128, 32, 0, 0);
    wait_ps(60000, n);
    check("first_ps_clocks", n + 1, 195 * 256);
    check("ramp1_duty0", int'(duty), 32);
    check("ramp1_busy", int'(busy), 1);
    check("ramp1_fv", int'(FINAL_VALUE), 0);
    check("ready_low_busy", int'(cmd_ready), 0);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_target = 9'd3;
    cmd_step   = 8'd200;
    @(negedge clk);
    cmd_valid  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_ps(1000, n);
      check("ramp1_gap", n + ((k == 0) ? 1 : 0), 256);
      check("ramp1_duty", int'(duty), exp2[k]);
      check("ramp1_done", int'(done), (k == 2) ? 1 : 0);
    end
    @(posedge clk); #1;
    check("ramp1_busy_after", int'(busy), 0);
    check("ramp1_done_after", int'(done), 0);

    // Ramp down 128 -> 10 by 50 with one extra dwell period.
    send(10, 50, 1, 0);
    for (int k = 0; k < 5; k++) begin
      wait_ps(1000, n);
      if (k > 0) check("ramp2_gap", n, 256);
      check("ramp2_duty", int'(duty), exp3[k]);
      check("ramp2_done", int'(done), (k == 4) ? 1 : 0);
    end

    // Clamp and zero-step normalisation, then a target equal to current duty.
    send(255, 245, 0, 0);
    wait_ps(1000, n);
    check("to255_duty", int'(duty), 255);
    send(300, 0, 0, 0);
    wait_ps(1000, n);
    check("clamp_duty", int'(duty), 256);
    check("clamp_done", int'(done), 1);
    send(256, 7, 0, 1);
    wait_ps(1000, n);
    check("same_duty", int'(duty), 256);
    check("same_done", int'(done), 1);
    check("same_fv", int'(FINAL_VALUE), 1);

    // Randomised ramps with ignored commands while busy.
    for (int i = 0; i < 4; i++) begin
      send(int'($urandom_range(0, 300)), int'($urandom_range(64, 255)),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 300)) @(posedge clk);
      #1;
      if (busy) begin
        check("rand_ready_low", int'(cmd_ready), 0);
        cmd_valid  = 1'b1;
        cmd_target = 9'($urandom_range(0, 300));
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
      end
      wait_idle(20000);
    end

`ifdef PWM_RAMP_ABORT_EN
    send(0, 255, 0, 0);
    wait_idle(5000);
    send(200, 64, 3, 0);
    wait_ps(2000, n);
    check("abort_pre_duty", int'(duty), 64);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_duty", int'(duty), 64);
    check("abort_done", int'(done), 0);
    check("abort_ready", int'(cmd_ready), 1);
    abort = 1'b1;
    send(64, 8, 0, 0);
    abort = 1'b0;
    check("abort_idle_accept", int'(busy), 1);
    wait_idle(5000);
`endif

    // Reset in the middle of a ramp.
    tgt = (duty > 9'd128) ? 0 : 256;
    send(tgt, 16, 0, 2);
    wait_ps(2000, n);
    repeat (100) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_duty", int'(duty), 0);
    check("midrst_fv", int'(FINAL_VALUE), 194);
    check("midrst_ready", int'(cmd_ready), 1);
    check("midrst_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    finish_run();
  end

endmodule
